// File: rtl/traceback_213_pkg.sv
// Shared decoder parameters for the (2,1,3) Viterbi traceback block.
// Holds default sizes, FSM encodings and the saturated metric value.
package traceback_213_pkg;

   localparam int FRAME_LEN_DEF = 16;
   localparam int W_DEF         = 4;
   localparam int NS_DEF        = 4;

   localparam logic [W_DEF-1:0] METRIC_SAT = '1;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      SELECT = 2'd1,
      TRACE  = 2'd2,
      EMIT   = 2'd3
   } tb_state_t;

endpackage

// File: rtl/traceback_213_minsel.sv
// Four-way unsigned argmin over packed path metrics.
// Ties always resolve toward the lower state index.
module tb213_minsel #(
   parameter int W = 4
) (
   input  logic [4*W-1:0] metrics,
   output logic [1:0]     min_idx
);

   logic [W-1:0] m0, m1, m2, m3;
   logic [W-1:0] v01, v23;
   logic         s01, s23, hi;

   assign m0 = metrics[0*W +: W];
   assign m1 = metrics[1*W +: W];
   assign m2 = metrics[2*W +: W];
   assign m3 = metrics[3*W +: W];

   // strict less-than keeps the lower index on equality
   assign s01 = m1 < m0;
   assign s23 = m3 < m2;
   assign v01 = s01 ? m1 : m0;
   assign v23 = s23 ? m3 : m2;
   assign hi  = v23 < v01;

   assign min_idx = hi ? {1'b1, s23} : {1'b0, s01};

endmodule

// File: rtl/traceback_213.sv
// Frame-based survivor traceback: stores ACS decisions, traces back
// from the best final state and emits decoded bits in forward order.
module traceback_213
   import traceback_213_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int W         = W_DEF,
   parameter int NS        = NS_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [NS-1:0]   dec_bx,
   input  logic [NS*W-1:0] dec_ppm,
   output logic            bit_valid,
   input  logic            bit_ready,
   output logic            bit_out,
   output logic            bit_last
);

   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

   tb_state_t state, state_nx;

   logic [IW-1:0]        idx;
   logic [1:0]           cur;
   logic [1:0]           min_idx;
   logic [NS*W-1:0]      ppm_q;
   logic [NS-1:0]        mem [FRAME_LEN];
   logic [FRAME_LEN-1:0] obuf;
   logic                 xfer_in, xfer_out;

   assign xfer_in  = dec_valid && dec_ready;
   assign xfer_out = bit_valid && bit_ready;

   tb213_minsel #(.W(W)) u_minsel (
      .metrics (ppm_q),
      .min_idx (min_idx)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= FILL;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         FILL:   if (xfer_in && idx == LAST) state_nx = SELECT;
         SELECT: state_nx = TRACE;
         TRACE:  if (idx == '0) state_nx = EMIT;
         EMIT:   if (xfer_out && idx == LAST) state_nx = FILL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx   <= '0;
         cur   <= '0;
         ppm_q <= '0;
      end else begin
         unique case (state)
            FILL: begin
               if (xfer_in) begin
                  if (idx == LAST) begin
                     idx   <= '0;
                     ppm_q <= dec_ppm;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            SELECT: begin
               idx <= LAST;
               cur <= min_idx;
            end
            TRACE: begin
               cur <= {cur[0], mem[idx][cur]};
               // index 0 is left in place as the first read index
               if (idx != '0) idx <= idx - 1'b1;
            end
            EMIT: begin
               if (xfer_out) idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (state == FILL && xfer_in) mem[idx] <= dec_bx;
      if (state == TRACE)           obuf[idx] <= cur[1];
   end

   assign dec_ready = state == FILL;
   assign bit_valid = state == EMIT;
   assign bit_out   = (state == EMIT) ? obuf[idx] : 1'b0;
   assign bit_last  = (state == EMIT) && (idx == LAST);

endmodule

// File: tb/tb_traceback_213.sv
// Directed bench for traceback_213 with hand-derived expected bit streams.
// Covers reset, latency, tie break, stalls and mid-frame/mid-emit reset.
module tb_traceback_213;

   logic        clock;
   logic        reset;
   logic        dec_valid;
   logic        dec_ready;
   logic [3:0]  dec_bx;
   logic [15:0] dec_ppm;
   logic        bit_valid;
   logic        bit_ready;
   logic        bit_out;
   logic        bit_last;

   int nvec;
   int nerr;

   logic [3:0]  bx_v [16];
   logic [15:0] ppm_v;
   logic [0:15] exp_v;
   logic [0:15] pat;
   int          lat;

   traceback_213 dut (
      .clock     (clock),
      .reset     (reset),
      .dec_valid (dec_valid),
      .dec_ready (dec_ready),
      .dec_bx    (dec_bx),
      .dec_ppm   (dec_ppm),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .bit_out   (bit_out),
      .bit_last  (bit_last)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_frame();
      int n;
      for (int i = 0; i < 16; i++) begin
         dec_valid = 1'b1;
         dec_bx    = bx_v[i];
         dec_ppm   = (i == 15) ? ppm_v : 16'h0;
         n = 0;
         while (!dec_ready && n < 60) begin
            tick();
            n++;
         end
         if (n >= 60) chk("send_timeout", 32'(n), 32'(0));
         tick();
      end
      dec_valid = 1'b0;
      dec_bx    = '0;
   endtask

   task automatic recv_frame(input string tag, input int stall_at,
                             input int stall_len);
      int  n;
      logic held;
      bit_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n = 0;
         while (!bit_valid && n < 60) begin
            tick();
            n++;
         end
         if (n >= 60) chk({tag, "_timeout"}, 32'(n), 32'(0));
         if (i == 0) lat = n;
         chk({tag, "_bit"}, 32'(bit_out), 32'(exp_v[i]));
         chk({tag, "_last"}, 32'(bit_last), 32'(i == 15));
         if (i == stall_at) begin
            bit_ready = 1'b0;
            held = bit_out;
            for (int k = 0; k < stall_len; k++) begin
               tick();
               chk({tag, "_hold_v"}, 32'(bit_valid), 32'(1));
               chk({tag, "_hold_b"}, 32'(bit_out), 32'(held));
               chk({tag, "_hold_r"}, 32'(dec_ready), 32'(0));
            end
            bit_ready = 1'b1;
         end
         tick();
      end
      bit_ready = 1'b0;
      chk({tag, "_end_v"}, 32'(bit_valid), 32'(0));
      chk({tag, "_end_r"}, 32'(dec_ready), 32'(1));
   endtask

   initial begin
      nvec      = 0;
      nerr      = 0;
      reset     = 1'b1;
      dec_valid = 1'b0;
      dec_bx    = '0;
      dec_ppm   = '0;
      bit_ready = 1'b0;
      pat       = 16'b1011001110001101;
      #1;
      chk("rst_valid", 32'(bit_valid), 32'(0));
      chk("rst_last", 32'(bit_last), 32'(0));
      chk("rst_out", 32'(bit_out), 32'(0));
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_ready", 32'(dec_ready), 32'(1));

      // all-zero frame, state 0 best
      for (int i = 0; i < 16; i++) bx_v[i] = 4'h0;
      ppm_v = {4'd15, 4'd15, 4'd15, 4'd0};
      exp_v = '0;
      send_frame();
      recv_frame("zero", -1, 0);
      chk("zero_latency", 32'(lat), 32'(17));

      // error-free encoder path: true state {u(t),u(t-1)} came from u(t-2)
      for (int t = 0; t < 16; t++) begin
         logic [1:0] s;
         logic       x;
         s = {pat[t], (t >= 1) ? pat[t-1] : 1'b0};
         x = (t >= 2) ? pat[t-2] : 1'b0;
         bx_v[t] = x ? 4'hF : 4'h0;
         bx_v[t][s] = x;
         for (int q = 0; q < 4; q++)
            if (q != int'(s)) bx_v[t][q] = ~x;
      end
      ppm_v = 16'hFFFF;
      ppm_v[{pat[15], pat[14]}*4 +: 4] = 4'd0;
      exp_v = pat;
      send_frame();
      recv_frame("enc", -1, 0);

      // metrics {3,1,1,7}: tie between 1 and 2 picks state 1
      for (int i = 0; i < 16; i++) bx_v[i] = 4'hF;
      ppm_v = {4'd7, 4'd1, 4'd1, 4'd3};
      exp_v = 16'b1111111111111110;
      send_frame();
      recv_frame("tie", -1, 0);

      // consumer stall at bit 4 for 5 cycles
      for (int t = 0; t < 16; t++) begin
         logic [1:0] s;
         logic       x;
         s = {pat[t], (t >= 1) ? pat[t-1] : 1'b0};
         x = (t >= 2) ? pat[t-2] : 1'b0;
         for (int q = 0; q < 4; q++) bx_v[t][q] = ~x;
         bx_v[t][s] = x;
      end
      ppm_v = 16'hFFFF;
      ppm_v[{pat[15], pat[14]}*4 +: 4] = 4'd2;
      exp_v = pat;
      send_frame();
      recv_frame("stall", 4, 5);

      // reset while presenting bit 7
      send_frame();
      bit_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         int n;
         n = 0;
         while (!bit_valid && n < 60) begin
            tick();
            n++;
         end
         tick();
      end
      chk("emit7_valid", 32'(bit_valid), 32'(1));
      chk("emit7_bit", 32'(bit_out), 32'(exp_v[7]));
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", 32'(bit_valid), 32'(0));
      chk("arst_last", 32'(bit_last), 32'(0));
      chk("arst_out", 32'(bit_out), 32'(0));
      bit_ready = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("arst_ready", 32'(dec_ready), 32'(1));

      // partial frame of 9 steps discarded by reset
      dec_valid = 1'b1;
      dec_bx    = 4'hF;
      repeat (9) tick();
      dec_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) bx_v[i] = 4'h0;
      ppm_v = {4'd15, 4'd15, 4'd15, 4'd0};
      exp_v = '0;
      send_frame();
      recv_frame("part", -1, 0);
      chk("part_latency", 32'(lat), 32'(17));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
